mips32_prog_loader: RTL and testbench

Byte-stream program loader for the MIPS32 pipeline core. It receives a framed image over a valid/ready byte interface and assembles big-endian 32-bit words. Each word goes to the core's unified instruction/data memory through a write port, and the core is held until the image is accepted. On a good checksum it releases the core with a start pulse; on any error the core stays held. This replaces hierarchical memory preloading with a synthesizable load path.

---
 rtl/mips32_pkg.sv | 31 +++
 rtl/mips32_prog_loader.sv | 222 ++++++++++++++++++++++
 tb/tb_mips32_prog_loader.sv | 277 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/mips32_pkg.sv
// Shared MIPS32 definitions: memory geometry, loader FSM states, loader error bits.
package mips32_pkg;

  localparam int unsigned MEM_WORDS    = 1024;
  localparam logic [7:0]  SYNC_DEFAULT = 8'hA5;

  localparam int unsigned ERR_CSUM    = 0;
  localparam int unsigned ERR_RANGE   = 1;
  localparam int unsigned ERR_TIMEOUT = 2;

  typedef enum logic [2:0] {
    StHunt,
    StAddrH,
    StAddrL,
    StCntH,
    StCntL,
    StData,
    StCsum,
    StStart
  } ld_state_e;

  // Full 16-bit base is checked so a base beyond the memory is also rejected.
  function automatic logic range_overflow(input logic [15:0]  base,
                                          input logic [15:0]  count,
                                          input int unsigned  addr_w);
    logic [16:0] sum;
    sum = {1'b0, base} + {1'b0, count};
    return sum > (17'd1 << addr_w);
  endfunction

endpackage

// File: rtl/mips32_prog_loader.sv
// Framed byte-stream loader: assembles big-endian words into core memory and
// holds the core until a frame with a good checksum has been written.
module mips32_prog_loader
  import mips32_pkg::*;
#(
  parameter int unsigned ADDR_W  = $clog2(MEM_WORDS),
  parameter logic [7:0]  SYNC    = SYNC_DEFAULT,
  parameter int unsigned TIMEOUT = 1000
) (
  input  logic              clk1,
  input  logic              rst_n,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [7:0]        s_data,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              cpu_hold,
  output logic              cpu_start,
  output logic              busy,
  output logic              done,
  output logic [2:0]        err
);

  localparam int unsigned TW = $clog2(TIMEOUT + 1);

  ld_state_e         state_q, state_d;
  logic              ready_q;
  logic [15:0]       base_q, base_d;
  logic [15:0]       count_q, count_d;
  logic [15:0]       words_q, words_d;
  logic [1:0]        byte_cnt_q, byte_cnt_d;
  logic [23:0]       shift_q, shift_d;
  logic [7:0]        csum_q, csum_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              we_q, we_d;
  logic              hold_q, hold_d;
  logic              done_q, done_d;
  logic              busy_q, busy_d;
  logic [2:0]        err_q, err_d;
  logic [TW-1:0]     idle_q, idle_d;

  logic        accept;
  logic [15:0] cnt_full;

  assign accept   = s_valid && s_ready;
  assign cnt_full = {count_q[15:8], s_data};

  always_comb begin
    state_d    = state_q;
    base_d     = base_q;
    count_d    = count_q;
    words_d    = words_q;
    byte_cnt_d = byte_cnt_q;
    shift_d    = shift_q;
    csum_d     = csum_q;
    ptr_d      = ptr_q;
    mem_addr_d = mem_addr_q;
    wdata_d    = wdata_q;
    we_d       = 1'b0;
    hold_d     = hold_q;
    done_d     = done_q;
    busy_d     = busy_q;
    err_d      = err_q;
    idle_d     = idle_q;

    unique case (state_q)
      StHunt: begin
        if (accept && s_data == SYNC) begin
          state_d = StAddrH;
          busy_d  = 1'b1;
          hold_d  = 1'b1;
          done_d  = 1'b0;
          err_d   = '0;
          csum_d  = '0;
        end
      end
      StAddrH: begin
        if (accept) begin
          base_d[15:8] = s_data;
          csum_d       = csum_q ^ s_data;
          state_d      = StAddrL;
        end
      end
      StAddrL: begin
        if (accept) begin
          base_d[7:0] = s_data;
          ptr_d       = ADDR_W'({base_q[15:8], s_data});
          csum_d      = csum_q ^ s_data;
          state_d     = StCntH;
        end
      end
      StCntH: begin
        if (accept) begin
          count_d[15:8] = s_data;
          csum_d        = csum_q ^ s_data;
          state_d       = StCntL;
        end
      end
      StCntL: begin
        if (accept) begin
          count_d    = cnt_full;
          words_d    = '0;
          byte_cnt_d = '0;
          csum_d     = csum_q ^ s_data;
          if (range_overflow(base_q, cnt_full, ADDR_W)) begin
            err_d[ERR_RANGE] = 1'b1;
          end
          state_d = (cnt_full == 16'd0) ? StCsum : StData;
        end
      end
      StData: begin
        if (accept) begin
          csum_d     = csum_q ^ s_data;
          shift_d    = {shift_q[15:0], s_data};
          byte_cnt_d = byte_cnt_q + 2'd1;
          if (byte_cnt_q == 2'd3) begin
            // After a range error the payload is drained but never written.
            if (!err_q[ERR_RANGE]) begin
              we_d       = 1'b1;
              wdata_d    = {shift_q, s_data};
              mem_addr_d = ptr_q;
            end
            ptr_d   = ptr_q + 1'b1;
            words_d = words_q + 16'd1;
            if (words_q + 16'd1 == count_q) begin
              state_d = StCsum;
            end
          end
        end
      end
      StCsum: begin
        if (accept) begin
          busy_d = 1'b0;
          if (s_data != csum_q) begin
            err_d[ERR_CSUM] = 1'b1;
          end
          if (s_data == csum_q && !err_q[ERR_RANGE]) begin
            state_d = StStart;
            hold_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            state_d = StHunt;
          end
        end
      end
      StStart: begin
        state_d = StHunt;
      end
      default: begin
        state_d = StHunt;
      end
    endcase

    // Idle watchdog only runs while a frame is open.
    if (accept) begin
      idle_d = '0;
    end else if (state_q != StHunt && state_q != StStart) begin
      if (idle_q == TW'(TIMEOUT - 1)) begin
        err_d[ERR_TIMEOUT] = 1'b1;
        busy_d             = 1'b0;
        state_d            = StHunt;
        idle_d             = '0;
      end else begin
        idle_d = idle_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StHunt;
      ready_q    <= 1'b0;
      base_q     <= '0;
      count_q    <= '0;
      words_q    <= '0;
      byte_cnt_q <= '0;
      shift_q    <= '0;
      csum_q     <= '0;
      ptr_q      <= '0;
      mem_addr_q <= '0;
      wdata_q    <= '0;
      we_q       <= 1'b0;
      hold_q     <= 1'b1;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
      err_q      <= '0;
      idle_q     <= '0;
    end else begin
      state_q    <= state_d;
      ready_q    <= 1'b1;
      base_q     <= base_d;
      count_q    <= count_d;
      words_q    <= words_d;
      byte_cnt_q <= byte_cnt_d;
      shift_q    <= shift_d;
      csum_q     <= csum_d;
      ptr_q      <= ptr_d;
      mem_addr_q <= mem_addr_d;
      wdata_q    <= wdata_d;
      we_q       <= we_d;
      hold_q     <= hold_d;
      done_q     <= done_d;
      busy_q     <= busy_d;
      err_q      <= err_d;
      idle_q     <= idle_d;
    end
  end

  assign s_ready   = ready_q && (state_q != StStart);
  assign mem_we    = we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = wdata_q;
  assign cpu_hold  = hold_q;
  assign cpu_start = (state_q == StStart);
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;

endmodule

// File: tb/tb_mips32_prog_loader.sv
// Directed bench for mips32_prog_loader: good/bad frames, range, timeout, resync, reset.
module tb_mips32_prog_loader;

  localparam int unsigned ADDR_W = 10;

  logic              clk1 = 1'b0;
  logic              rst_n = 1'b0;
  logic              s_valid = 1'b0;
  logic              s_ready;
  logic [7:0]        s_data = 8'h00;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              cpu_hold;
  logic              cpu_start;
  logic              busy;
  logic              done;
  logic [2:0]        err;

  int checks = 0;
  int errors = 0;

  logic [31:0] prog[$];
  logic [31:0] wr_addr[$];
  logic [31:0] wr_data[$];
  int          start_cnt = 0;
  bit          gap_en = 1'b0;

  mips32_prog_loader #(
    .ADDR_W (ADDR_W),
    .SYNC   (8'hA5),
    .TIMEOUT(1000)
  ) u_dut (
    .clk1     (clk1),
    .rst_n    (rst_n),
    .s_valid  (s_valid),
    .s_ready  (s_ready),
    .s_data   (s_data),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .cpu_hold (cpu_hold),
    .cpu_start(cpu_start),
    .busy     (busy),
    .done     (done),
    .err      (err)
  );

  always #5 clk1 = ~clk1;

  always @(negedge clk1) begin
    if (mem_we) begin
      wr_addr.push_back(32'(mem_addr));
      wr_data.push_back(mem_wdata);
    end
    if (cpu_start) start_cnt++;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic clear_mon();
    wr_addr.delete();
    wr_data.delete();
    start_cnt = 0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    if (gap_en) repeat ($urandom_range(0, 3)) @(negedge clk1);
    @(negedge clk1);
    s_valid = 1'b1;
    s_data  = b;
    while (!s_ready && n < 100) begin
      @(negedge clk1);
      n++;
    end
    if (!s_ready) check_val("send_stall", 32'(s_ready), 32'd1);
    @(posedge clk1);
    #1;
    s_valid = 1'b0;
  endtask

  function automatic logic [7:0] calc_csum(input logic [15:0] base);
    logic [7:0]  c;
    logic [15:0] cnt;
    cnt = 16'(prog.size());
    c = base[15:8] ^ base[7:0] ^ cnt[15:8] ^ cnt[7:0];
    foreach (prog[i]) c = c ^ prog[i][31:24] ^ prog[i][23:16] ^ prog[i][15:8] ^ prog[i][7:0];
    return c;
  endfunction

  // Sends a whole frame from prog; checks the write strobe right after each 4th byte.
  task automatic send_frame(input logic [15:0] base, input logic [7:0] csum, input logic exp_we);
    logic [15:0]       cnt;
    logic [31:0]       w;
    logic [ADDR_W-1:0] a;
    cnt = 16'(prog.size());
    send_byte(8'hA5);
    check_val("busy_after_sync", 32'(busy), 32'd1);
    send_byte(base[15:8]);
    send_byte(base[7:0]);
    send_byte(cnt[15:8]);
    send_byte(cnt[7:0]);
    for (int i = 0; i < prog.size(); i++) begin
      w = prog[i];
      for (int b = 0; b < 4; b++) send_byte(w[31-8*b -: 8]);
      check_val("we_strobe", 32'(mem_we), 32'(exp_we));
      if (exp_we) begin
        a = base[ADDR_W-1:0] + ADDR_W'(i);
        check_val("we_addr", 32'(mem_addr), 32'(a));
        check_val("we_data", mem_wdata, w);
      end
    end
    send_byte(csum);
  endtask

  task automatic check_writes(input logic [15:0] base);
    logic [ADDR_W-1:0] a;
    check_val("write_count", 32'(wr_addr.size()), 32'(prog.size()));
    for (int i = 0; i < prog.size() && i < wr_addr.size(); i++) begin
      a = base[ADDR_W-1:0] + ADDR_W'(i);
      check_val("mon_addr", wr_addr[i], 32'(a));
      check_val("mon_data", wr_data[i], prog[i]);
    end
  endtask

  task automatic check_idle_reset(input string tag);
    check_val({tag, "_ready"}, 32'(s_ready), 32'd0);
    check_val({tag, "_we"}, 32'(mem_we), 32'd0);
    check_val({tag, "_addr"}, 32'(mem_addr), 32'd0);
    check_val({tag, "_wdata"}, mem_wdata, 32'd0);
    check_val({tag, "_hold"}, 32'(cpu_hold), 32'd1);
    check_val({tag, "_start"}, 32'(cpu_start), 32'd0);
    check_val({tag, "_busy"}, 32'(busy), 32'd0);
    check_val({tag, "_done"}, 32'(done), 32'd0);
    check_val({tag, "_err"}, 32'(err), 32'd0);
  endtask

  initial begin
    // Reset state and first ready edge
    repeat (3) @(posedge clk1);
    #1;
    check_idle_reset("reset");
    @(negedge clk1);
    rst_n = 1'b1;
    @(posedge clk1);
    #1;
    check_val("ready_after_reset", 32'(s_ready), 32'd1);

    // Test program, good checksum (0xC7 hand-computed)
    prog = '{32'h28010078, 32'h0c631800, 32'h20220000, 32'h0c631800,
             32'h2842002d, 32'h0c631800, 32'h24220001, 32'h00832800};
    clear_mon();
    send_frame(16'h0000, 8'hC7, 1'b1);
    check_val("good_start", 32'(cpu_start), 32'd1);
    check_val("good_hold", 32'(cpu_hold), 32'd0);
    check_val("good_done", 32'(done), 32'd1);
    check_val("good_busy", 32'(busy), 32'd0);
    check_val("good_ready_start", 32'(s_ready), 32'd0);
    @(posedge clk1);
    #1;
    check_val("good_start_pulse", 32'(cpu_start), 32'd0);
    check_val("good_ready_after", 32'(s_ready), 32'd1);
    check_val("good_err", 32'(err), 32'd0);
    check_writes(16'h0000);
    check_val("good_start_cnt", 32'(start_cnt), 32'd1);

    // Same frame, corrupted checksum
    clear_mon();
    send_frame(16'h0000, 8'hC6, 1'b1);
    repeat (3) @(posedge clk1);
    #1;
    check_writes(16'h0000);
    check_val("bad_err", 32'(err), 32'b001);
    check_val("bad_hold", 32'(cpu_hold), 32'd1);
    check_val("bad_done", 32'(done), 32'd0);
    check_val("bad_busy", 32'(busy), 32'd0);
    check_val("bad_start_cnt", 32'(start_cnt), 32'd0);

    // Range error: base 0x03FE, 3 words
    prog = '{32'h11111111, 32'h22222222, 32'h33333333};
    clear_mon();
    send_frame(16'h03FE, calc_csum(16'h03FE), 1'b0);
    repeat (3) @(posedge clk1);
    #1;
    check_val("range_err", 32'(err), 32'b010);
    check_val("range_writes", 32'(wr_addr.size()), 32'd0);
    check_val("range_start_cnt", 32'(start_cnt), 32'd0);
    check_val("range_hold", 32'(cpu_hold), 32'd1);

    // Timeout after CNT_L; next SYNC must clear err
    send_byte(8'hA5);
    check_val("resync_busy", 32'(busy), 32'd1);
    check_val("resync_err_clr", 32'(err), 32'd0);
    send_byte(8'h00);
    send_byte(8'h00);
    send_byte(8'h00);
    send_byte(8'h01);
    repeat (999) @(posedge clk1);
    #1;
    check_val("tmo_early_err", 32'(err), 32'd0);
    check_val("tmo_early_busy", 32'(busy), 32'd1);
    @(posedge clk1);
    #1;
    check_val("tmo_err", 32'(err), 32'b100);
    check_val("tmo_busy", 32'(busy), 32'd0);
    check_val("tmo_hold", 32'(cpu_hold), 32'd1);
    clear_mon();
    repeat (4) send_byte(8'h00);
    check_val("tmo_hunt_busy", 32'(busy), 32'd0);
    check_val("tmo_hunt_err", 32'(err), 32'b100);
    check_val("tmo_hunt_writes", 32'(wr_addr.size()), 32'd0);

    // Garbage before sync, A5 in payload, random gaps
    gap_en = 1'b1;
    send_byte(8'h00);
    send_byte(8'hFF);
    send_byte(8'h5A);
    check_val("garbage_busy", 32'(busy), 32'd0);
    prog = '{32'hA5A5A5A5, 32'h12A534A5, 32'hDEADBEEF};
    clear_mon();
    send_frame(16'h0010, calc_csum(16'h0010), 1'b1);
    repeat (3) @(posedge clk1);
    #1;
    check_writes(16'h0010);
    check_val("payload_start_cnt", 32'(start_cnt), 32'd1);
    check_val("payload_done", 32'(done), 32'd1);
    check_val("payload_err", 32'(err), 32'd0);
    gap_en = 1'b0;

    // Reset in the middle of word 2
    send_byte(8'hA5);
    send_byte(8'h01);
    send_byte(8'h00);
    send_byte(8'h00);
    send_byte(8'h02);
    send_byte(8'hCA);
    send_byte(8'hFE);
    send_byte(8'hBA);
    send_byte(8'hBE);
    send_byte(8'h12);
    send_byte(8'h34);
    @(negedge clk1);
    rst_n = 1'b0;
    #1;
    check_idle_reset("midreset");
    @(negedge clk1);
    rst_n = 1'b1;
    @(posedge clk1);
    #1;
    prog = '{32'h0BADF00D, 32'hA5000001};
    clear_mon();
    send_frame(16'h0100, calc_csum(16'h0100), 1'b1);
    check_val("reload_start", 32'(cpu_start), 32'd1);
    repeat (2) @(posedge clk1);
    #1;
    check_writes(16'h0100);
    check_val("reload_done", 32'(done), 32'd1);
    check_val("reload_hold", 32'(cpu_hold), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
